down_timer: RTL and testbench



---
 rtl/down_timer.sv | 111 +++++++++++
 tb/tb_down_timer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with one-shot and auto-reload modes.
//
// Counts a loaded value down to zero one step per cycle while dec is high, and
// emits a single-cycle terminal-count pulse on tc. In one-shot mode the timer
// parks in DONE at q=0; in auto-reload mode q is refilled from the reload
// register and counting continues.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   ld        load data into q and the reload register (highest priority)
//   dec       decrement enable, one count per cycle while high
//   stop      abort countdown, q holds its value
//   mode      0 = one-shot, 1 = auto-reload (sampled at terminal count)
//   data      load value
//   q         current count (registered)
//   tc        terminal-count pulse (registered, one cycle)
//   busy      high while counting (RUN)
//   done      high after a one-shot has expired (DONE)
//   dbg_state current FSM state encoding, for observation only
//
// Handshake: there is no valid/ready pair; each control input is a level that
// is sampled on every rising clk edge, with priority ld > stop > dec.
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             dec,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // State register together with the registered datapath outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      q      <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      reload <= reload_nxt;
      tc     <= tc_nxt;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    reload_nxt = reload;
    tc_nxt     = 1'b0;
    if (ld) begin
      // A load always wins, even over a pending terminal count; mode is not
      // consulted and no tc is produced.
      q_nxt      = data;
      reload_nxt = data;
      state_nxt  = (data != '0) ? RUN : IDLE;
    end else if (stop) begin
      // RUN aborts with q held; DONE returns to IDLE, clearing done.
      if (state != IDLE) begin
        state_nxt = IDLE;
      end
    end else if (dec && state == RUN) begin
      if (q == ONE) begin
        tc_nxt = 1'b1;
        if (mode) begin
          q_nxt = reload;
        end else begin
          q_nxt     = '0;
          state_nxt = DONE;
        end
      end else if (q != '0) begin
        q_nxt = q - ONE;
      end else begin
        // RUN with q=0 cannot be reached through a load; recover to IDLE.
        state_nxt = IDLE;
      end
    end
  end

  // Output decode from the registered state.
  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;
  localparam int W = 8;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ld = 1'b0, dec = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [W-1:0] data = '0;
  logic [W-1:0] q;
  logic         tc, busy, done;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  down_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ld(ld), .dec(dec), .stop(stop), .mode(mode),
    .data(data), .q(q), .tc(tc), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int tc_seen = 0;

  // Reference model: a counter value, the reload value and two flags saying
  // whether a countdown is in progress or a one-shot has expired.
  logic [W-1:0] m_q = '0, m_reload = '0;
  bit           m_running = 0, m_expired = 0, m_tc = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_reload = '0; m_running = 0; m_expired = 0; m_tc = 0;
  endtask

  task automatic model_step(input bit i_ld, input bit i_stop, input bit i_dec,
                            input bit i_mode, input logic [W-1:0] i_data);
    m_tc = 0;
    if (i_ld) begin
      m_q = i_data; m_reload = i_data;
      m_running = (i_data != 0); m_expired = 0;
    end else if (i_stop) begin
      m_running = 0; m_expired = 0;
    end else if (i_dec && m_running) begin
      if (int'(m_q) == 1) begin
        m_tc = 1;
        if (i_mode) m_q = m_reload;
        else begin
          m_q = 0; m_running = 0; m_expired = 1;
        end
      end else begin
        m_q = W'(int'(m_q) - 1);
      end
    end
    exp_q.push_back(m_q);
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check({tag, ".q"}, q, e);
    check({tag, ".tc"}, tc, m_tc);
    check({tag, ".busy"}, busy, m_running);
    check({tag, ".done"}, done, m_expired);
    if (tc === 1'b1) tc_seen++;
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: drive, clock, check 1 time unit later.
  task automatic cyc(input string tag, input bit i_ld, input bit i_stop, input bit i_dec,
                     input bit i_mode, input logic [W-1:0] i_data);
    ld = i_ld; stop = i_stop; dec = i_dec; mode = i_mode; data = i_data;
    @(posedge clk);
    model_step(i_ld, i_stop, i_dec, i_mode, i_data);
    #1 check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ld = 0; stop = 0; dec = 0; mode = 0; data = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held across edges.
    repeat (3) @(posedge clk);
    #1;
    check("rst.q", q, 0);
    check("rst.tc", tc, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // dec without a load does nothing.
    repeat (3) cyc("nold", 0, 0, 1, 0, 8'd0);
    check("nold.q_const", q, 0);

    // One-shot from 5.
    tc_seen = 0;
    cyc("os_ld", 1, 0, 0, 0, 8'd5);
    check("os_ld.q_const", q, 5);
    repeat (6) cyc("os", 0, 0, 1, 0, 8'd0);
    check("os.q_end", q, 0);
    check("os.done_end", done, 1);
    check("os.tc_count", tc_seen, 1);

    // Auto-reload from 3.
    tc_seen = 0;
    cyc("ar_ld", 1, 0, 0, 1, 8'd3);
    repeat (9) cyc("ar", 0, 0, 1, 1, 8'd0);
    check("ar.q_end", q, 3);
    check("ar.tc_count", tc_seen, 3);

    // Auto-reload with reload=1: tc on every dec.
    tc_seen = 0;
    cyc("ar1_ld", 1, 0, 0, 1, 8'd1);
    repeat (4) cyc("ar1", 0, 0, 1, 1, 8'd0);
    check("ar1.tc_count", tc_seen, 4);

    // Stop and reload.
    cyc("st_ld", 1, 0, 0, 0, 8'd10);
    repeat (4) cyc("st_dec", 0, 0, 1, 0, 8'd0);
    cyc("st_stop", 0, 1, 1, 0, 8'd0);
    check("st.q_held", q, 6);
    check("st.busy", busy, 0);
    repeat (3) cyc("st_hold", 0, 0, 1, 0, 8'd0);
    check("st.q_still", q, 6);
    cyc("st_reld", 1, 0, 0, 0, 8'd2);
    check("st.reld_q", q, 2);
    check("st.reld_busy", busy, 1);

    // Collision: ld beats terminal count.
    cyc("col_dec", 0, 0, 1, 0, 8'd0);
    check("col.q1", q, 1);
    cyc("col_ld", 1, 0, 1, 0, 8'd7);
    check("col_ld.q", q, 7);
    check("col_ld.tc", tc, 0);
    // Collision: stop beats terminal count.
    repeat (6) cyc("col_dec2", 0, 0, 1, 1, 8'd0);
    cyc("col_stop", 0, 1, 1, 1, 8'd0);
    check("col_stop.q", q, 1);
    check("col_stop.tc", tc, 0);
    check("col_stop.state", dbg_state, 0);

    // Zero load.
    cyc("zero_ld", 1, 0, 1, 0, 8'd0);
    check("zero.q", q, 0);
    check("zero.busy", busy, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit r_ld, r_stop, r_dec, r_mode;
      logic [W-1:0] r_data;
      r_ld   = ($urandom_range(0, 99) < 8);
      r_stop = ($urandom_range(0, 99) < 5);
      r_dec  = ($urandom_range(0, 99) < 75);
      r_mode = $urandom_range(0, 1);
      r_data = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom_range(0, 20));
      cyc("rnd", r_ld, r_stop, r_dec, r_mode, r_data);
    end

    // Async reset mid-count.
    cyc("ar_rst_ld", 1, 0, 0, 0, 8'd200);
    repeat (50) cyc("ar_rst_dec", 0, 0, 1, 0, 8'd0);
    check("pre_rst.q", q, 150);
    #2 rst = 1'b0;
    #1;
    check("async.q", q, 0);
    check("async.busy", busy, 0);
    check("async.tc", tc, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cyc("post_rst", 0, 0, 1, 0, 8'd0);
    check("post_rst.q_const", q, 0);

    idle_inputs();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
